// File: rtl/crank_rate_meter.sv
// crank_rate_meter: period-to-rate meter for one active-low crank/wheel sensor.
// Synchronises and debounces the pin, times the interval between falling
// edges, block-averages 2^AVG_LOG intervals and divides SCALE*N by the sum
// with a bit-serial restoring divider. Rate is forced to 0 on timeout.
module crank_rate_meter #(
    parameter int CNT_W    = 32,
    parameter int OUT_W    = 10,
    parameter int SCALE    = 768000,
    parameter int TIMEOUT  = 64000,
    parameter int DEBOUNCE = 2,
    parameter int AVG_LOG  = 0
) (
    input  logic             clock,
    input  logic             nRst,
    input  logic             nPulse,
    output logic [OUT_W-1:0] rate,
    output logic             rate_valid,
    output logic             stale,
    output logic             overrun
);

    localparam int DB_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
    localparam int AC_W = AVG_LOG + 1;
    localparam int BC_W = $clog2(CNT_W);
    localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] SCALE_V  = CNT_W'(SCALE);
    localparam logic [CNT_W-1:0] DIVIDEND = SCALE_V << AVG_LOG;
    localparam logic [AC_W-1:0]  N_LAST   = AC_W'((1 << AVG_LOG) - 1);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    // input path
    logic            sync1, sync2, flt_q, flt_d, flt, ev;
    logic [DB_W-1:0] dcnt;

    // measurement path
    logic [CNT_W-1:0] cnt, acc, acc_nx, pend_dvd, pend_dvs;
    logic [CNT_W:0]   acc_sum;
    logic [AC_W-1:0]  nsmp;
    logic             armed, pend_full, to_hit, capture, submit, take;

    // divider
    state_t           state;
    logic [CNT_W-1:0] quo, rem, dvs;
    logic [CNT_W:0]   shl, dif;
    logic [BC_W-1:0]  bcnt;
    logic             ge;

    // Synchroniser plus debounce: level flips after DEBOUNCE differing samples in a row
    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            flt_q <= 1'b1;
            flt_d <= 1'b1;
            dcnt  <= '0;
        end else begin
            sync1 <= nPulse;
            sync2 <= sync1;
            flt_d <= flt;
            if (DEBOUNCE != 0) begin
                if (sync2 != flt_q) begin
                    if (dcnt == DB_W'(DEBOUNCE - 1)) begin
                        flt_q <= sync2;
                        dcnt  <= '0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end else begin
                    dcnt <= '0;
                end
            end
        end
    end

    assign flt = (DEBOUNCE == 0) ? sync2 : flt_q;
    assign ev  = flt_d & ~flt;

    // An event always beats a coincident timeout
    assign to_hit  = !ev && (cnt == TMO - 1'b1);
    assign capture = ev && armed;
    assign submit  = capture && (nsmp == N_LAST);
    assign take    = (state == S_IDLE) && pend_full;
    assign acc_sum = {1'b0, acc} + {1'b0, cnt};
    assign acc_nx  = acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];

    // Interval counter, arming, block accumulator and the single pending slot
    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            cnt       <= '0;
            armed     <= 1'b0;
            acc       <= '0;
            nsmp      <= '0;
            pend_full <= 1'b0;
            pend_dvd  <= '0;
            pend_dvs  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (ev)              cnt <= CNT_W'(1);
            else if (cnt != TMO) cnt <= cnt + 1'b1;

            if (ev)          armed <= 1'b1;
            else if (to_hit) armed <= 1'b0;

            if (to_hit) begin
                acc       <= '0;
                nsmp      <= '0;
                pend_full <= 1'b0;
            end else begin
                if (submit) begin
                    acc      <= '0;
                    nsmp     <= '0;
                    pend_dvd <= DIVIDEND;
                    pend_dvs <= acc_nx;
                    if (pend_full && !take) overrun <= 1'b1;
                end else if (capture) begin
                    acc  <= acc_nx;
                    nsmp <= nsmp + 1'b1;
                end
                if (submit)    pend_full <= 1'b1;
                else if (take) pend_full <= 1'b0;
            end
        end
    end

    assign shl = {rem, quo[CNT_W-1]};
    assign dif = shl - {1'b0, dvs};
    assign ge  = !dif[CNT_W];

    // Divider FSM and registered outputs; timeout aborts any division in flight
    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            state      <= S_IDLE;
            quo        <= '0;
            rem        <= '0;
            dvs        <= '0;
            bcnt       <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
            stale      <= 1'b1;
        end else begin
            rate_valid <= 1'b0;
            if (to_hit) begin
                state      <= S_IDLE;
                rate       <= '0;
                rate_valid <= 1'b1;
                stale      <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: if (pend_full) begin
                        quo   <= pend_dvd;
                        dvs   <= pend_dvs;
                        rem   <= '0;
                        bcnt  <= BC_W'(CNT_W - 1);
                        state <= S_DIV;
                    end
                    S_DIV: begin
                        rem  <= ge ? dif[CNT_W-1:0] : shl[CNT_W-1:0];
                        quo  <= {quo[CNT_W-2:0], ge};
                        bcnt <= bcnt - 1'b1;
                        if (bcnt == '0) state <= S_DONE;
                    end
                    S_DONE: begin
                        rate       <= (|quo[CNT_W-1:OUT_W]) ? '1 : quo[OUT_W-1:0];
                        rate_valid <= 1'b1;
                        stale      <= 1'b0;
                        state      <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crank_rate_meter.sv
// Four instances run side by side: defaults, DEBOUNCE=4, AVG_LOG=2, DEBOUNCE=0.
// Each has its own pulse driver and expectation queue; a negedge monitor pops
// an entry on every rate_valid strobe and checks rate, stale and arrival cycle.
module tb_crank_rate_meter;

    typedef struct {
        int cyc;
        int rate;
        int stale;
    } exp_t;

    logic       clk = 1'b0;
    int         cyc = 0;
    logic       nrst  [4];
    logic       np    [4];
    logic [9:0] rate_w[4];
    logic       rv_w  [4];
    logic       st_w  [4];
    logic       ov_w  [4];
    bit         mon_en[4];
    exp_t       sbq   [4][$];
    int         lat   [4] = '{39, 41, 39, 37};
    int         n_chk = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crank_rate_meter u0 (
        .clock(clk), .nRst(nrst[0]), .nPulse(np[0]), .rate(rate_w[0]),
        .rate_valid(rv_w[0]), .stale(st_w[0]), .overrun(ov_w[0]));
    crank_rate_meter #(.DEBOUNCE(4)) u1 (
        .clock(clk), .nRst(nrst[1]), .nPulse(np[1]), .rate(rate_w[1]),
        .rate_valid(rv_w[1]), .stale(st_w[1]), .overrun(ov_w[1]));
    crank_rate_meter #(.AVG_LOG(2)) u2 (
        .clock(clk), .nRst(nrst[2]), .nPulse(np[2]), .rate(rate_w[2]),
        .rate_valid(rv_w[2]), .stale(st_w[2]), .overrun(ov_w[2]));
    crank_rate_meter #(.DEBOUNCE(0)) u3 (
        .clock(clk), .nRst(nrst[3]), .nPulse(np[3]), .rate(rate_w[3]),
        .rate_valid(rv_w[3]), .stale(st_w[3]), .overrun(ov_w[3]));

    task automatic chk(input string tag, input int got, input int want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d (cyc %0d)", tag, got, want, cyc);
        end
    endtask

    // wait (from a #1-after-posedge point) until cycle t, then drive the pin
    task automatic drive_at(input int i, input int t, input logic v);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
        np[i] = v;
    endtask

    task automatic fall(input int i, input int t, input int len);
        drive_at(i, t, 1'b0);
        drive_at(i, t + len, 1'b1);
    endtask

    task automatic push(input int i, input int c, input int r, input int s);
        exp_t e;
        e.cyc = c; e.rate = r; e.stale = s;
        sbq[i].push_back(e);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mon_en[i] && rv_w[i] === 1'b1) begin
                if (sbq[i].size() == 0) begin
                    chk($sformatf("u%0d_unexpected_strobe", i), 1, 0);
                end else begin
                    exp_t e;
                    e = sbq[i].pop_front();
                    chk($sformatf("u%0d_rate", i), int'(rate_w[i]), e.rate);
                    chk($sformatf("u%0d_stale", i), int'(st_w[i]), e.stale);
                    chk($sformatf("u%0d_strobe_cycle", i), cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            nrst[i] = 1'b0;
            np[i]   = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rate", int'(rate_w[0]), 0);
        chk("rst_valid", int'(rv_w[0]), 0);
        chk("rst_stale", int'(st_w[0]), 1);
        chk("rst_overrun", int'(ov_w[0]), 0);
        chk("rst_stale_avg", int'(st_w[2]), 1);
        for (int i = 0; i < 4; i++) begin
            nrst[i]   = 1'b1;
            mon_en[i] = 1'b1;
        end
        @(posedge clk);
        #1;

        fork
            begin : ph_default
                int b;
                b = cyc + 10;
                fall(0, b, 50);                          // arms only
                push(0, b + 12800 + lat[0], 60, 0);
                fall(0, b + 12800, 50);
                push(0, b + 13800 + lat[0], 768, 0);
                fall(0, b + 13800, 50);
                push(0, b + 14300 + lat[0], 1023, 0);    // 1536 saturates
                fall(0, b + 14300, 50);
                push(0, b + 14300 + 4 + 64000, 0, 1);    // timeout strobe
                drive_at(0, b + 14300 + 64050, 1'b1);
                chk("tmo_stale", int'(st_w[0]), 1);
                chk("tmo_rate", int'(rate_w[0]), 0);
                chk("def_overrun", int'(ov_w[0]), 0);
                fall(0, b + 78400, 50);                  // re-arms only
                push(0, b + 79400 + lat[0], 768, 0);
                fall(0, b + 79400, 50);
                drive_at(0, b + 79500, 1'b1);
                chk("u0_drain", sbq[0].size(), 0);
                mon_en[0] = 1'b0;
            end
            begin : ph_debounce
                int b;
                b = cyc + 10;
                fall(1, b, 50);
                fall(1, b + 3000, 1);                    // glitches that must vanish
                fall(1, b + 5000, 2);
                fall(1, b + 7000, 3);
                push(1, b + 12800 + lat[1], 60, 0);
                fall(1, b + 12800, 50);
                push(1, b + 19200 + lat[1], 120, 0);     // 5-cycle glitch passes
                fall(1, b + 19200, 5);
                push(1, b + 25600 + lat[1], 120, 0);
                fall(1, b + 25600, 50);
                drive_at(1, b + 25800, 1'b1);
                chk("u1_drain", sbq[1].size(), 0);
                mon_en[1] = 1'b0;
            end
            begin : ph_avg
                int b;
                b = cyc + 10;
                fall(2, b, 50);
                fall(2, b + 12000, 50);
                fall(2, b + 25000, 50);
                fall(2, b + 37800, 50);
                push(2, b + 51200 + lat[2], 60, 0);      // sum 51200 over 4
                fall(2, b + 51200, 50);
                drive_at(2, b + 51300, 1'b1);
                chk("u2_drain", sbq[2].size(), 0);
                mon_en[2] = 1'b0;
            end
            begin : ph_overrun
                int b;
                mon_en[3] = 1'b0;
                b = cyc + 10;
                for (int k = 0; k < 6; k++) fall(3, b + 20 * k, 5);
                drive_at(3, b + 110, 1'b1);
                chk("ovr_set", int'(ov_w[3]), 1);
                chk("ovr_rate_sat", int'(rate_w[3]), 1023);
                chk("ovr_stale", int'(st_w[3]), 0);
                drive_at(3, b + 135, 1'b1);
                chk("ovr_hold", int'(ov_w[3]), 1);
                nrst[3] = 1'b0;                          // mid-division
                #1;
                chk("mid_rst_rate", int'(rate_w[3]), 0);
                chk("mid_rst_valid", int'(rv_w[3]), 0);
                chk("mid_rst_stale", int'(st_w[3]), 1);
                chk("mid_rst_overrun", int'(ov_w[3]), 0);
                repeat (3) @(posedge clk);
                #1;
                nrst[3]   = 1'b1;
                mon_en[3] = 1'b1;                        // empty queue: any strobe fails
                drive_at(3, cyc + 300, 1'b1);
                chk("post_rst_stale", int'(st_w[3]), 1);
                chk("post_rst_overrun", int'(ov_w[3]), 0);
                mon_en[3] = 1'b0;
            end
        join

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/crank_rate_meter.md
Name: crank_rate_meter

Overview:
- Parametrised successor to the single-channel cadence counter.
- Measures the interval between filtered falling edges of an active-low sensor pulse (crank or wheel), optionally block-averages N intervals, and computes rate = SCALE*N / sum_of_intervals with an internal sequential divider.
- Adds input synchronisation, debounce, averaging, output saturation, a stale flag and overrun detection.
- Sits between the sensor pin and the display/formatting logic; one instance per sensor.

Parameters:
- CNT_W, 32, width of the interval counter, accumulator and divider.
- OUT_W, 10, width of the rate output.
- SCALE, 768000, rate numerator per interval (60 s * 12800 Hz tick for rev/min).
- TIMEOUT, 64000, interval in clocks after which the rate is forced to 0.
- DEBOUNCE, 2, consecutive equal samples needed to change the filtered level; 0 disables the filter.
- AVG_LOG, 0, log2 of the number of intervals averaged per result (N = 2^AVG_LOG).

Ports:
- clock  input  1  system clock (tick rate assumed by SCALE).
- nRst  input  1  reset: asynchronous, active-low.
- nPulse  input  1  raw active-low sensor, asynchronous to clock.
- rate  output  OUT_W  latest computed rate, saturated.
- rate_valid  output  1  one-cycle strobe when rate is updated, including the update to 0 on timeout.
- stale  output  1  high when no valid measurement exists (after reset or timeout).
- overrun  output  1  sticky: a captured measurement was overwritten before the divider accepted it.

Behaviour:
- Reset values (async, nRst=0): rate=0, rate_valid=0, stale=1, overrun=0. Internal state: sync=1, filtered level=1, counter=0, disarmed, divider idle, pending empty, accumulator=0, sample count=0.
- Input path: 2-flop synchroniser on nPulse. The debounce counter counts samples that differ from the filtered level and resets on any matching sample. The filtered level toggles when the count reaches DEBOUNCE.
- Event: filtered level transitions 1->0. A stable falling input produces an event 2+DEBOUNCE clocks later.
- Interval counter cnt:
  - On an event, cnt <= 1.
  - Otherwise cnt <= cnt+1, saturating at TIMEOUT.
  - The interval captured at an event equals cnt in that cycle, so events D clocks apart give D.
- Arming: the first event after reset or timeout only arms the meter; nothing is captured.
- Averaging:
  - Each captured interval is added to the accumulator and the sample count is incremented.
  - When the count reaches N, {dividend = SCALE<<AVG_LOG, divisor = accumulator} is loaded into the single-slot pending register, and the accumulator and count clear.
  - With AVG_LOG=0, every interval is submitted.
- Divider FSM: states IDLE, DIV, DONE.
  - IDLE -> DIV when pending is full. Consumes pending the same cycle.
  - DIV: restoring division, one quotient bit per cycle, CNT_W cycles.
  - DONE, one cycle: rate <= (quotient > 2^OUT_W-1) ? all-ones : quotient[OUT_W-1:0]; rate_valid=1; stale=0. Then -> IDLE.
  - Latency from the pending load to the rate_valid strobe is CNT_W+2 clocks when the divider is idle.
- Overrun: if pending is full and not yet consumed when a new submission arrives, the new value overwrites pending and overrun sets. overrun clears only on reset.
- Timeout: the cycle cnt reaches TIMEOUT:
  - rate <= 0 and rate_valid=1 (one strobe only, not repeated while saturated); stale <= 1.
  - Disarm; clear the accumulator, sample count and pending; abort any division in progress (its result is discarded).
- Simultaneous timeout and event: the event wins. cnt <= 1, the meter arms, no capture occurs, and no timeout action is taken.
- Simultaneous pending load and divider DONE: both happen; the next division starts the following cycle.
- Arithmetic: all internal values are unsigned CNT_W. The divisor is never 0 because the minimum interval is 1. The accumulator saturates at all-ones.

Test Plan:
- Defaults, clean pulses every 12800 clocks -> after the 2nd edge, rate_valid strobes CNT_W+2 cycles after capture with rate=60, stale=0.
- Defaults, pulses every 1000 clocks -> rate=768. Pulses every 500 clocks -> quotient 1536 saturates to rate=1023.
- DEBOUNCE=4, 1-3-cycle glitches injected between real edges every 12800 clocks -> no extra events, rate stays 60. A 5-cycle glitch -> interval shortened, rate changes.
- Pulses stop after rate=60 -> exactly TIMEOUT=64000 clocks after the last event: rate=0, single rate_valid strobe, stale=1. The next edge only arms, and the edge after it yields a result.
- AVG_LOG=2, intervals 12000, 13000, 12800, 13400 (sum 51200) -> one result rate=60 after the 4th interval, no intermediate strobes.
- Interval 20 clocks (less than CNT_W+2) with DEBOUNCE=0 -> overrun=1 and stays set. Assert nRst mid-division -> all outputs return to reset values immediately, with no rate_valid after release.
